oled_box_animator: RTL
======================

Name: oled_box_animator

Overview:
- Parametrised successor to the team's single-screen OLED task generator.
- Draws one BOX_SIZE square on a WIDTH x HEIGHT RGB565 OLED. Three debounced buttons start, stop and reverse its horizontal motion and cycle its colour.
- Position updates are frame-synchronous to avoid tearing.
- Sits between the button inputs and the Oled_Display pixel_index/pixel_data interface, clocked on the display pixel clock.

Parameters:
- WIDTH, 96, display columns
- HEIGHT, 64, display rows
- BOX_SIZE, 10, square edge in pixels (1..HEIGHT)
- STEP, 4, pixels moved per frame while moving
- DEBOUNCE_CYCLES, 12500, stable cycles required before a button change is accepted (2 ms at 6.25 MHz)
- IDX_W, 13, pixel_index width

Ports:
- clk  in  1  display pixel clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- btn_left  in  1  raw asynchronous button
- btn_right  in  1  raw asynchronous button
- btn_centre  in  1  raw asynchronous button
- frame_begin  in  1  one-cycle pulse at start of each frame
- pixel_index  in  IDX_W  linear index, row-major, x = idx % WIDTH, y = idx / WIDTH
- pixel_data  out  16  RGB565 colour for pixel_index
- box_x  out  7  left column of the box
- motion  out  2  0 IDLE, 1 LEFT, 2 RIGHT

Behaviour:
- Reset:
  - Applies at the clk edge when reset_n = 0.
  - Values: box_x = (WIDTH-BOX_SIZE)/2 = 43; motion = IDLE; colour index 0; pixel_data = 16'h0000.
  - Clears synchroniser and debounce state and any pending press.
  - Reset mid-frame takes effect next cycle; no partial move survives.
- Input conditioning, per button:
  - 2-FF synchroniser, then a debounce counter.
  - Counter resets on any change vs. the accepted level. At DEBOUNCE_CYCLES-1 the accepted level updates.
  - A 0->1 transition of the accepted level emits a one-cycle press pulse.
- Press handling (FSM states IDLE, LEFT, RIGHT):
  - left press: IDLE->LEFT; RIGHT->LEFT; LEFT->IDLE.
  - right press: IDLE->RIGHT; LEFT->RIGHT; RIGHT->IDLE.
  - Left and right pulses in the same cycle: both ignored, state unchanged.
  - centre press: colour index increments mod 4 (palette F800, 07E0, 001F, FFFF), independent of the FSM.
  - Centre press coincident with a direction press: both take effect.
- Motion update occurs only on the cycle frame_begin = 1:
  - LEFT: if box_x >= STEP, box_x -= STEP; else box_x = 0 and motion -> IDLE.
  - RIGHT: if box_x + STEP <= WIDTH-BOX_SIZE, box_x += STEP; else box_x = WIDTH-BOX_SIZE and motion -> IDLE.
  - A press in the same cycle as frame_begin: the state transition happens first; the move uses the new state.
  - Clamp arithmetic is done at width 8 to avoid underflow.
- Pixel path:
  - Registered, latency exactly 1 cycle from pixel_index to pixel_data.
  - Box rows are y in [(HEIGHT-BOX_SIZE)/2, (HEIGHT-BOX_SIZE)/2 + BOX_SIZE).
  - Inside the box: palette colour. Elsewhere: 16'h0000.
  - pixel_index >= WIDTH*HEIGHT outputs 16'h0000.
  - x and y are derived by an incrementing column/row counter pair that tracks pixel_index. A non-sequential index resynchronises through division by constant.

Optional Feature:
- Macro OLED_BORDER_EN.
- Defined: pixels with x = 0, x = WIDTH-1, y = 0 or y = HEIGHT-1 output 16'h07FF (cyan).
  - Border has priority over the box.
  - LEFT/RIGHT clamp limits become 1 and WIDTH-1-BOX_SIZE; the reset position is unchanged.
- Undefined: no border; the limits are 0 and WIDTH-BOX_SIZE as stated above.

Decomposition:
- Package oled_pkg: RGB565 colour constants (BLACK, RED, GREEN, BLUE, WHITE, CYAN), motion enum (IDLE/LEFT/RIGHT, 2-bit), palette array.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset_n, raw, level, press), instantiated three times.

Test Plan:
- DEBOUNCE_CYCLES = 4 for all scenarios.
- Reset:
  - Stimulus: hold reset_n = 0 for 3 cycles, release.
  - Required: box_x = 43, motion = 0, pixel_data = 0. After 1 cycle, pixel_index = 31*96+43 = 3019 gives pixel_data = F800.
- Debounce:
  - Stimulus: btn_right glitches high for 2 cycles, then is held high for 10 cycles.
  - Required: no transition from the glitch. Exactly one RIGHT transition, about 6 cycles after the stable rise (2 synchroniser + 4 debounce).
- Motion:
  - Stimulus: motion RIGHT, then 5 frame_begin pulses.
  - Required: box_x = 43, 47, 51, 55, 59, 63. Later frames give 67, 71, 75, 79, 83, 86; motion returns to 0 at 86.
- Reversal and simultaneous presses:
  - In LEFT, a right press gives RIGHT.
  - A right press in RIGHT gives IDLE.
  - Left and right pulses in the same cycle leave the state unchanged.
- Colour:
  - Stimulus: four centre presses.
  - Required: box colour 07E0, 001F, FFFF, F800 in turn. Pixel 0 and index 6144 stay 0000, or 07FF for pixel 0 under OLED_BORDER_EN.

Source files
------------

// File: rtl/oled_box_animator_pkg.sv
// Shared colour constants, motion encoding and box palette for the OLED box animator.
package oled_pkg;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] CYAN  = 16'h07FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } motion_e;

  localparam logic [15:0] PALETTE [4] = '{RED, GREEN, BLUE, WHITE};

endpackage

// File: rtl/oled_box_animator_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debounce and a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 12500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Count only while the synchronised input disagrees with the accepted level.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_p1;
        press <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_box_animator.sv
// Animated square on an RGB565 OLED: button-driven horizontal motion, frame-synchronous moves,
// colour cycling and a 1-cycle registered pixel path. Define OLED_BORDER_EN for a cyan frame border.
module oled_box_animator
  import oled_pkg::*;
#(
  parameter int WIDTH           = 96,
  parameter int HEIGHT          = 64,
  parameter int BOX_SIZE        = 10,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 12500,
  parameter int IDX_W           = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_centre,
  input  logic             frame_begin,
  input  logic [IDX_W-1:0] pixel_index,
  output logic [15:0]      pixel_data,
  output logic [6:0]       box_x,
  output logic [1:0]       motion
);

  localparam int X_HOME = (WIDTH - BOX_SIZE) / 2;
  localparam int Y_TOP  = (HEIGHT - BOX_SIZE) / 2;
`ifdef OLED_BORDER_EN
  localparam int X_LO = 1;
  localparam int X_HI = WIDTH - 1 - BOX_SIZE;
`else
  localparam int X_LO = 0;
  localparam int X_HI = WIDTH - BOX_SIZE;
`endif

  logic left_level, right_level, centre_level;
  logic left_press, right_press, centre_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset_n(reset_n), .raw(btn_left), .level(left_level), .press(left_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset_n(reset_n), .raw(btn_right), .level(right_level), .press(right_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_centre (
    .clk(clk), .reset_n(reset_n), .raw(btn_centre), .level(centre_level), .press(centre_press));

  motion_e    state_q, state_mid, state_d;
  logic [6:0] box_q, box_d;
  logic [7:0] box_w;
  logic [1:0] colour_q;

  // Presses resolve first; a coincident frame_begin then moves using the resolved state.
  always_comb begin
    state_mid = state_q;
    if (left_press && !right_press) begin
      state_mid = (state_q == LEFT) ? IDLE : LEFT;
    end else if (right_press && !left_press) begin
      state_mid = (state_q == RIGHT) ? IDLE : RIGHT;
    end
    state_d = state_mid;
    box_d   = box_q;
    box_w   = {1'b0, box_q};
    if (frame_begin) begin
      case (state_mid)
        LEFT: begin
          if (box_w >= 8'(X_LO + STEP)) begin
            box_d = 7'(box_w - 8'(STEP));
          end else begin
            box_d   = 7'(X_LO);
            state_d = IDLE;
          end
        end
        RIGHT: begin
          if (box_w + 8'(STEP) <= 8'(X_HI)) begin
            box_d = 7'(box_w + 8'(STEP));
          end else begin
            box_d   = 7'(X_HI);
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      box_q    <= 7'(X_HOME);
      colour_q <= 2'd0;
    end else begin
      state_q <= state_d;
      box_q   <= box_d;
      if (centre_press) colour_q <= colour_q + 2'd1;
    end
  end

  logic [IDX_W-1:0] prev_idx_q, prev_x_q, prev_y_q;
  logic [IDX_W-1:0] x_c, y_c;
  logic             seq;
  logic             in_box;
  logic [15:0]      pix_d;

  // Index 0 always takes the division path so a wrap from the last index cannot desynchronise.
  assign seq = (pixel_index == prev_idx_q + IDX_W'(1)) && (pixel_index != '0);

  always_comb begin
    x_c = pixel_index % IDX_W'(WIDTH);
    y_c = pixel_index / IDX_W'(WIDTH);
    if (seq) begin
      if (prev_x_q == IDX_W'(WIDTH - 1)) begin
        x_c = '0;
        y_c = prev_y_q + IDX_W'(1);
      end else begin
        x_c = prev_x_q + IDX_W'(1);
        y_c = prev_y_q;
      end
    end
  end

  always_comb begin
    in_box = (x_c >= IDX_W'(box_q)) && (x_c < IDX_W'(box_q) + IDX_W'(BOX_SIZE)) &&
             (y_c >= IDX_W'(Y_TOP)) && (y_c < IDX_W'(Y_TOP + BOX_SIZE));
    pix_d  = BLACK;
    if (pixel_index >= IDX_W'(WIDTH * HEIGHT)) begin
      pix_d = BLACK;
`ifdef OLED_BORDER_EN
    end else if ((x_c == '0) || (x_c == IDX_W'(WIDTH - 1)) ||
                 (y_c == '0) || (y_c == IDX_W'(HEIGHT - 1))) begin
      pix_d = CYAN;
`endif
    end else if (in_box) begin
      pix_d = PALETTE[colour_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_idx_q <= '0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      pixel_data <= BLACK;
    end else begin
      prev_idx_q <= pixel_index;
      prev_x_q   <= x_c;
      prev_y_q   <= y_c;
      pixel_data <= pix_d;
    end
  end

  assign box_x  = box_q;
  assign motion = state_q;

endmodule
